// File: rtl/arf132b256e1r1w0cbbehcaa4acw_rd_ctl.sv
// Read-side controller for the 132b x 256 1R1W array: request -> array read -> credit-guarded response FIFO.
// Response appears RD_LAT+1 cycles after accept; requests stall when in-flight reads plus FIFO occupancy reach FIFO_DEPTH.
module arf132b256e1r1w0cbbehcaa4acw_rd_ctl #(
  parameter int DATA_W     = 132,
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_vld,
  output logic              rd_req_rdy,
  input  logic [ADDR_W-1:0] rd_req_adr,
  output logic              arr_rd_en,
  output logic [ADDR_W-1:0] arr_rd_adr,
  input  logic [DATA_W-1:0] arr_rd_dat,
  output logic              arr_rd_clken,
  output logic              rd_rsp_vld,
  input  logic              rd_rsp_rdy,
  output logic [DATA_W-1:0] rd_rsp_dat,
  output logic              ovf_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CRD_W = $clog2(FIFO_DEPTH + 1);

  logic [CRD_W-1:0]  credits;
  logic [RD_LAT-1:0] lat_pipe;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              acc;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;

  // Ready depends only on registered credits, so a pop is seen one cycle later.
  assign rd_req_rdy   = ~rst & (credits < CRD_W'(FIFO_DEPTH));
  assign acc          = rd_req_vld & rd_req_rdy;
  assign arr_rd_en    = acc;
  assign arr_rd_adr   = rd_req_adr;
  assign arr_rd_clken = rd_req_vld | (|lat_pipe);

  assign push  = lat_pipe[RD_LAT-1];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = rd_rsp_rdy & ~empty;

  assign rd_rsp_vld = ~empty;
  assign rd_rsp_dat = mem[rd_ptr[PTR_W-1:0]];

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) lat_pipe <= '0;
        else     lat_pipe <= acc;
      end
    end else begin : g_latn
      always_ff @(posedge clk) begin
        if (rst) lat_pipe <= '0;
        else     lat_pipe <= {lat_pipe[RD_LAT-2:0], acc};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= '0;
    end else if (acc && !pop) begin
      credits <= credits + CRD_W'(1);
    end else if (!acc && pop) begin
      credits <= credits - CRD_W'(1);
    end
  end

  // A pop in the same cycle frees the head slot, so a push into a full FIFO is legal then.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && (!full || pop)) begin
        mem[wr_ptr[PTR_W-1:0]] <= arr_rd_dat;
        wr_ptr                 <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) ovf_err <= 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: tb/tb_arf132b256e1r1w0cbbehcaa4acw_rd_ctl.sv
// Bench for the read controller: one instance per RD_LAT (1..3), directed vectors plus a random phase, scoreboard-checked.
module tb_arf132b256e1r1w0cbbehcaa4acw_rd_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  // Array contents as seen by the bench: 0x2A reads back as {2A, D5, 0..., A5}.
  function automatic logic [131:0] arr_word(input logic [7:0] a);
    return {a, ~a, 108'h0, a ^ 8'h8F};
  endfunction

  task automatic chk_b(input string nm, input int lat, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (RD_LAT=%0d): got %b, expected %b", nm, lat, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int lat, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (RD_LAT=%0d): got %0d, expected %0d", nm, lat, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input int lat, input logic [131:0] act, input logic [131:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (RD_LAT=%0d): got %h, expected %h", nm, lat, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int L = g + 1;

    logic         rst;
    logic         vld;
    logic         rdy;
    logic [7:0]   adr;
    logic         en;
    logic [7:0]   aadr;
    logic [131:0] adat;
    logic         clken;
    logic         rvld;
    logic         rrdy;
    logic [131:0] rdat;
    logic         ovf;
    logic [7:0]   ap [L];
    logic [L-1:0] ep;
    logic [131:0] sbq [$];

    arf132b256e1r1w0cbbehcaa4acw_rd_ctl #(
      .DATA_W(132), .ADDR_W(8), .RD_LAT(L), .FIFO_DEPTH(4)
    ) dut (
      .clk(clk), .rst(rst),
      .rd_req_vld(vld), .rd_req_rdy(rdy), .rd_req_adr(adr),
      .arr_rd_en(en), .arr_rd_adr(aadr), .arr_rd_dat(adat), .arr_rd_clken(clken),
      .rd_rsp_vld(rvld), .rd_rsp_rdy(rrdy), .rd_rsp_dat(rdat),
      .ovf_err(ovf)
    );

    // Array model: data valid exactly L cycles after the read enable, junk otherwise.
    always @(posedge clk) begin
      ap[0] <= aadr;
      ep[0] <= en;
      for (int i = 1; i < L; i++) begin
        ap[i] <= ap[i-1];
        ep[i] <= ep[i-1];
      end
    end
    assign adat = ep[L-1] ? arr_word(ap[L-1]) : {33{4'hC}};

    // Scoreboard: push on accept, pop and compare on every handshaken response.
    always @(negedge clk) begin
      if (rst) begin
        sbq.delete();
      end else begin
        if (vld && rdy) sbq.push_back(arr_word(adr));
        if (rvld && rrdy) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected response (RD_LAT=%0d): got %h, expected none", L, rdat);
          end else begin
            chk_d("response data", L, rdat, sbq.pop_front());
          end
        end
      end
    end

    task automatic issue(input logic [7:0] a, input bit rnd);
      int t = 0;
      vld = 1'b1;
      adr = a;
      if (rnd) rrdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      while (!rdy && t < 100) begin
        @(posedge clk); #1;
        t++;
        if (rnd) rrdy = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      chk_b("request accepted", L, rdy, 1'b1);
      @(posedge clk); #1;
      vld = 1'b0;
    endtask

    task automatic drain();
      int t = 0;
      vld  = 1'b0;
      rrdy = 1'b1;
      while ((sbq.size() != 0 || rvld) && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      chk_b("drained", L, (sbq.size() == 0) && !rvld, 1'b1);
    endtask

    initial begin
      int acc_cnt;
      int t;
      rst = 1'b1; vld = 1'b0; adr = '0; rrdy = 1'b0;

      // Reset state
      @(posedge clk); #1;
      @(negedge clk);
      chk_b("rdy during rst", L, rdy, 1'b0);
      chk_b("rsp_vld after rst", L, rvld, 1'b0);
      chk_d("rsp_dat after rst", L, rdat, '0);
      chk_b("ovf after rst", L, ovf, 1'b0);
      chk_b("clken idle", L, clken, 1'b0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk_b("rdy after rst", L, rdy, 1'b1);

      // Single read: exact latency, data and clock-enable window
      @(posedge clk); #1; rrdy = 1'b1; vld = 1'b1; adr = 8'h2A;
      @(negedge clk);
      chk_b("clken on vld", L, clken, 1'b1);
      chk_b("single accept", L, rdy, 1'b1);
      @(posedge clk); #1; vld = 1'b0;
      for (int k = 1; k <= L + 1; k++) begin
        @(negedge clk);
        chk_b("clken hold", L, clken, k <= L);
        chk_b("rsp_vld timing", L, rvld, k == L + 1);
        if (k == L + 1) chk_d("rsp_dat 0x2A", L, rdat, {8'h2A, 8'hD5, 108'h0, 8'hA5});
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk_b("rsp popped", L, rvld, 1'b0);
      @(posedge clk); #1;

      // Six back-to-back requests with responses stalled: only four fit
      rrdy = 1'b0; acc_cnt = 0; vld = 1'b1;
      for (int i = 0; i < 6; i++) begin
        adr = 8'h10 + 8'(acc_cnt);
        @(negedge clk);
        if (rdy) acc_cnt++;
        @(posedge clk); #1;
      end
      chk_i("accepted while stalled", L, acc_cnt, 4);
      @(negedge clk);
      chk_b("rdy at full credits", L, rdy, 1'b0);
      @(posedge clk); #1; rrdy = 1'b1;
      t = 0;
      while (acc_cnt < 6 && t < 50) begin
        adr = 8'h10 + 8'(acc_cnt);
        @(negedge clk);
        if (rdy) acc_cnt++;
        @(posedge clk); #1;
        t++;
      end
      vld = 1'b0;
      chk_i("remaining accepted", L, acc_cnt, 6);
      drain();
      chk_b("ovf after stall", L, ovf, 1'b0);

      // Accept and pop together at three credits
      rrdy = 1'b0;
      for (int i = 0; i < 3; i++) issue(8'h30 + 8'(i), 1'b0);
      repeat (L + 2) begin @(posedge clk); #1; end
      vld = 1'b1; adr = 8'h33; rrdy = 1'b1;
      @(negedge clk);
      chk_b("acc+pop rdy", L, rdy, 1'b1);
      chk_b("acc+pop rsp_vld", L, rvld, 1'b1);
      @(posedge clk); #1; rrdy = 1'b0; adr = 8'h34;
      @(negedge clk);
      chk_b("rdy at credits 3", L, rdy, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk_b("rdy at credits 4", L, rdy, 1'b0);
      @(posedge clk); #1; vld = 1'b0;
      drain();

      // Pointer wrap: addresses 0..9 with intermittent response stall
      for (int i = 0; i < 10; i++) begin
        rrdy = (i % 3) != 2;
        issue(8'(i), 1'b0);
      end
      drain();

      // Reset with reads in flight and in the FIFO
      rrdy = 1'b0;
      issue(8'h40, 1'b0);
      repeat (L) begin @(posedge clk); #1; end
      issue(8'h41, 1'b0);
      issue(8'h42, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk_b("rdy during mid rst", L, rdy, 1'b0);
      @(posedge clk); #1; rst = 1'b0; rrdy = 1'b1;
      for (int k = 0; k < L + 4; k++) begin
        @(negedge clk);
        chk_b("no stale rsp", L, rvld, 1'b0);
        @(posedge clk); #1;
      end
      chk_d("rsp_dat after mid rst", L, rdat, '0);
      rrdy = 1'b0;
      for (int i = 0; i < 4; i++) issue(8'h50 + 8'(i), 1'b0);
      vld = 1'b1; adr = 8'h54;
      @(negedge clk);
      chk_b("credits full after rst", L, rdy, 1'b0);
      @(posedge clk); #1; vld = 1'b0;
      drain();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
        repeat ($urandom_range(0, 2)) begin
          rrdy = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        issue(8'($urandom), 1'b1);
      end
      drain();
      chk_b("ovf never set", L, ovf, 1'b0);
      n_done++;
    end
  end

  initial begin
    int t = 0;
    while (n_done < 3 && t < 80000) begin
      @(posedge clk);
      t++;
    end
    if (n_done < 3) begin
      n_chk++;
      n_fail++;
      $display("FAIL completion timeout: got %0d instances done, expected 3", n_done);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
